cdb_arbiter: RTL
================

# cdb_arbiter

Shares the single common data bus (CDB) between the ALU and LSB result producers, so that RS, LSB and ROB snoop exactly one broadcast per cycle. Each source writes into its own small FIFO. An uncontended result bypasses its empty FIFO. Contention is resolved round-robin, and a hold signal throttles each source's issue logic before its FIFO can overflow. The block sits between the execution units and all CDB consumers. Rollback flushes it.

## Interface
- `ROB_ID_W`, 4: ROB tag width (matches `ROB_ID_WID`).
- `DATA_W`, 32: result width.
- `DEPTH`, 4: entries per source FIFO. Power of two, ≥2.
- `HOLD_MARGIN`, 2: free entries that must remain before hold deasserts.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global enable. When low, all state is frozen.
- `rollback`  in  1  synchronous flush on mispredict.
- `alu_valid`, `alu_rob_id`, `alu_data`  in  1/ROB_ID_W/DATA_W  ALU result.
- `lsb_valid`, `lsb_rob_id`, `lsb_data`  in  1/ROB_ID_W/DATA_W  LSB result.
- `alu_hold`  out  1  the ALU-side issuer must not dispatch.
- `lsb_hold`  out  1  the LSB must not start new loads.
- `cdb_valid`  out  1  broadcast valid this cycle.
- `cdb_rob_id`  out  ROB_ID_W  tag of the broadcast.
- `cdb_data`  out  DATA_W  value of the broadcast.
- `cdb_from_lsb`  out  1  1 = LSB source, 0 = ALU source.
- `overflow_err`  out  1  sticky flag. Set when a result arrives at a full FIFO.

## Operation
- **Per-source FIFO.** Each source has a circular FIFO with `DEPTH` entries, read/write pointers of log2(DEPTH) bits that wrap naturally, and a count register of log2(DEPTH)+1 bits.
- **Candidate.** A source's candidate is its FIFO head when count>0. Otherwise it is the incoming result when that source's valid is high. Otherwise the source has no candidate.
- **Grant.**
  - Exactly one candidate: that source is granted.
  - Two candidates: the source other than `last_grant` is granted.
  - `last_grant` updates on every grant.
- **Granted source, each edge:**
  - Candidate is registered onto the `cdb_*` outputs with `cdb_valid` = 1.
  - If the candidate was the FIFO head: pop it, and push any incoming valid result in the same edge (count unchanged).
  - If the candidate was the incoming result (bypass): nothing is written to the FIFO.
- **Non-granted source:** an incoming valid result is pushed. FIFO order is strictly preserved.
- **No candidates:** `cdb_valid` is 0 next cycle. `cdb_rob_id`, `cdb_data` and `cdb_from_lsb` hold their previous values.
- **Overflow.**
  - Condition: valid arrives, count == DEPTH, and no pop on this edge.
  - Effect: the result is dropped and `overflow_err` is set. It clears only on reset.
  - A correct system never triggers this, because the hold signals prevent it.
- **Hold.** `alu_hold` = (alu_count ≥ DEPTH−HOLD_MARGIN); `lsb_hold` likewise. Both are combinational from the count registers.
- **Rollback** (rdy high, `rollback` high):
  - Both FIFOs are emptied: count = 0, pointers = 0.
  - `cdb_valid` goes to 0 and `last_grant` goes to LSB.
  - Inputs are ignored on that edge.
- **Reset** (rst low, at any time, including mid-drain):
  - Immediately: FIFOs empty, `last_grant` = LSB (so the ALU wins the first tie).
  - All outputs 0: `cdb_valid`, `cdb_rob_id`, `cdb_data`, `cdb_from_lsb`, `overflow_err`, `alu_hold`, `lsb_hold`.
- **Freeze.** When `rdy` is low, no state changes and the inputs are ignored.

## Timing
- **Uncontended latency:** 1 cycle. A result valid in cycle c appears on the CDB in cycle c+1. This is the bypass path.
- **Contended latency:** the loser appears no earlier than c+2. With both sources streaming every cycle, the outputs alternate ALU/LSB.
- **Throughput:** exactly one broadcast per cycle whenever any FIFO is non-empty or any input is valid.
- **Hold timing:** hold is visible in the cycle after the push that raised the count. HOLD_MARGIN=2 covers the one-cycle RS→ALU dispatch pipeline plus one in-flight result.
- **Priority of simultaneous events:** rst > rollback > normal. Push and pop on the same FIFO in the same edge is legal at any count, including count == DEPTH.

## Test plan
- **Single ALU result.** After reset, `alu_valid`=1 with tag 3 and data 0x1234 for one cycle. Next cycle: `cdb_valid`=1, tag 3, data 0x1234, `cdb_from_lsb`=0. The cycle after: `cdb_valid`=0.
- **Tie.** ALU (tag 1, data 0xA) and LSB (tag 2, data 0xB) valid in the same cycle. Cycle +1 broadcasts ALU tag 1. Cycle +2 broadcasts LSB tag 2. Both FIFOs are then empty.
- **Round-robin streaming.** Both sources valid for 6 cycles with ALU tags 0–5 and LSB tags 8–13. Expected CDB order: A0 L8 A1 L9 A2 L10 A3 L11 A4 L12 A5 L13. Check `alu_hold` rises once alu_count reaches 2. `overflow_err` stays 0.
- **Overflow.** DEPTH=4. The LSB streams continuously and the ALU streams ignoring `alu_hold` until alu_count=4, then sends a 5th ALU result while that FIFO is not granted. Expected: `overflow_err`=1, the 5th result never appears on the CDB, and the earlier 4 ALU results appear in order.
- **Rollback.** Both FIFOs hold 2 entries and `rollback` is pulsed. Next cycle: `cdb_valid`=0, both hold signals 0. A subsequent LSB result appears after 1 cycle.
- **Async reset mid-drain.** Drop `rst` asynchronously mid-cycle while draining. All outputs must be 0 before the next clock edge. After release, a new ALU result broadcasts with 1-cycle latency.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer results in, single CDB broadcast and hold/overflow status out
interface cdb_arbiter_if #(
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32
);
   logic                alu_valid;
   logic [ROB_ID_W-1:0] alu_rob_id;
   logic [DATA_W-1:0]   alu_data;
   logic                lsb_valid;
   logic [ROB_ID_W-1:0] lsb_rob_id;
   logic [DATA_W-1:0]   lsb_data;
   logic                alu_hold;
   logic                lsb_hold;
   logic                cdb_valid;
   logic [ROB_ID_W-1:0] cdb_rob_id;
   logic [DATA_W-1:0]   cdb_data;
   logic                cdb_from_lsb;
   logic                overflow_err;
   modport master (
      output alu_valid, alu_rob_id, alu_data, lsb_valid, lsb_rob_id, lsb_data,
      input  alu_hold, lsb_hold, cdb_valid, cdb_rob_id, cdb_data, cdb_from_lsb, overflow_err
   );
   modport slave (
      input  alu_valid, alu_rob_id, alu_data, lsb_valid, lsb_rob_id, lsb_data,
      output alu_hold, lsb_hold, cdb_valid, cdb_rob_id, cdb_data, cdb_from_lsb, overflow_err
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of one CDB between ALU and LSB, with per-source FIFOs and bypass
module cdb_arbiter #(
   parameter int ROB_ID_W    = 4,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int HOLD_MARGIN = 2
) (
   input logic         clk,
   input logic         rst,
   input logic         rdy,
   input logic         rollback,
   cdb_arbiter_if.slave io
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ROB_ID_W + DATA_W;
   logic [EW-1:0] mem [2][DEPTH];
   logic [PW-1:0] wp [2];
   logic [PW-1:0] rp [2];
   logic [CW-1:0] cnt [2];
   logic [EW-1:0] in_e [2];
   logic [EW-1:0] cand_e [2];
   logic [1:0]    in_v, head, cand, gnt, pop, push, ovf;
   logic          last_lsb;
   logic          g_lsb;
   // index 0 is the ALU source, index 1 the LSB source
   assign in_v    = {io.lsb_valid, io.alu_valid};
   assign in_e[0] = {io.alu_rob_id, io.alu_data};
   assign in_e[1] = {io.lsb_rob_id, io.lsb_data};
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         head[s]   = cnt[s] != '0;
         cand[s]   = head[s] | in_v[s];
         cand_e[s] = head[s] ? mem[s][rp[s]] : in_e[s];
      end
   end
   assign g_lsb = cand[1] & (~cand[0] | ~last_lsb);
   assign gnt   = {g_lsb, cand[0] & ~g_lsb};
   // a bypassed result is consumed by the grant and never enters its FIFO
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         pop[s]  = gnt[s] & head[s];
         ovf[s]  = in_v[s] & (cnt[s] == CW'(DEPTH)) & ~pop[s];
         push[s] = in_v[s] & ~(gnt[s] & ~head[s]) & ~ovf[s];
      end
   end
   assign io.alu_hold = cnt[0] >= CW'(DEPTH - HOLD_MARGIN);
   assign io.lsb_hold = cnt[1] >= CW'(DEPTH - HOLD_MARGIN);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < 2; s++) begin
            wp[s]  <= '0;
            rp[s]  <= '0;
            cnt[s] <= '0;
         end
         last_lsb        <= 1'b1;
         io.cdb_valid    <= 1'b0;
         io.cdb_rob_id   <= '0;
         io.cdb_data     <= '0;
         io.cdb_from_lsb <= 1'b0;
         io.overflow_err <= 1'b0;
      end else if (rdy) begin
         if (rollback) begin
            for (int s = 0; s < 2; s++) begin
               wp[s]  <= '0;
               rp[s]  <= '0;
               cnt[s] <= '0;
            end
            last_lsb     <= 1'b1;
            io.cdb_valid <= 1'b0;
         end else begin
            for (int s = 0; s < 2; s++) begin
               wp[s]  <= wp[s] + PW'(push[s]);
               rp[s]  <= rp[s] + PW'(pop[s]);
               cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
            io.overflow_err <= io.overflow_err | (|ovf);
            io.cdb_valid    <= |gnt;
            if (|gnt) begin
               {io.cdb_rob_id, io.cdb_data} <= cand_e[g_lsb];
               io.cdb_from_lsb <= g_lsb;
               last_lsb        <= g_lsb;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++)
         if (rst && rdy && !rollback && push[s]) mem[s][wp[s]] <= in_e[s];
   end
endmodule
